// File: rtl/seq_bit_deserializer_if.sv
// Serial-bit input and parallel-word output handshakes of seq_bit_deserializer.
// slave is the deserializer side, master is the producer/consumer side.
interface seq_bit_deserializer_if #(
  parameter int NBITS = 8
);
  logic                     in_val;
  logic                     in_bit;
  logic                     in_rdy;
  logic                     out_val;
  logic [NBITS-1:0]         out_data;
  logic                     out_rdy;
  logic [$clog2(NBITS)-1:0] bit_count;

  modport slave (
    input  in_val,
    input  in_bit,
    output in_rdy,
    output out_val,
    output out_data,
    input  out_rdy,
    output bit_count
  );

  modport master (
    output in_val,
    output in_bit,
    input  in_rdy,
    input  out_val,
    input  out_data,
    output out_rdy,
    input  bit_count
  );
endinterface

// File: rtl/seq_bit_deserializer.sv
// Packs a valid/ready single-bit stream MSB-first into NBITS-bit words and
// holds each completed word in a one-entry output register.
module seq_bit_deserializer #(
  parameter int NBITS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        clear,
  seq_bit_deserializer_if.slave       bus
);
  localparam int            CW   = $clog2(NBITS);
  localparam logic [CW-1:0] LAST = CW'(NBITS - 1);

  logic [NBITS-1:0] sreg;
  logic [NBITS-1:0] odata;
  logic [CW-1:0]    cnt;
  logic             ovalid;
  logic             last_bit;
  logic             in_fire;
  logic             out_fire;

  // in_rdy comes from registered state only, so out_rdy never reaches it.
  assign last_bit     = (cnt == LAST);
  assign bus.in_rdy   = !(ovalid && last_bit);
  assign in_fire      = bus.in_val && bus.in_rdy && !clear;
  assign out_fire     = ovalid && bus.out_rdy;

  assign bus.out_val   = ovalid;
  assign bus.out_data  = odata;
  assign bus.bit_count = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sreg   <= '0;
      cnt    <= '0;
      odata  <= '0;
      ovalid <= 1'b0;
    end else begin
      if (clear) begin
        sreg <= '0;
        cnt  <= '0;
      end else if (in_fire) begin
        if (last_bit) begin
          sreg <= '0;
          cnt  <= '0;
        end else begin
          sreg <= {sreg[NBITS-2:0], bus.in_bit};
          cnt  <= cnt + 1'b1;
        end
      end

      // A completing bit beats a same-cycle dequeue: the new word stays valid.
      if (in_fire && last_bit) begin
        odata  <= {sreg[NBITS-2:0], bus.in_bit};
        ovalid <= 1'b1;
      end else if (out_fire) begin
        ovalid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_bit_deserializer.sv
// Directed bench for seq_bit_deserializer (NBITS=8): table-driven vectors
// plus hand-written backpressure, clear and reset sequences.
module tb_seq_bit_deserializer;
  logic clk;
  logic reset;
  logic clear;
  int   checks;
  int   errors;

  seq_bit_deserializer_if #(.NBITS(8)) bif ();

  seq_bit_deserializer #(.NBITS(8)) dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic       ib;
    logic       ordy;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic       cd;
    logic [2:0] ec;
    logic       er;
    string      nm;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic iv, input logic ib, input logic ordy, input logic clr,
                     input logic ev, input logic [7:0] ed, input logic cd,
                     input logic [2:0] ec, input logic er, input string nm);
    vec_t v;
    v.iv = iv; v.ib = ib; v.ordy = ordy; v.clr = clr;
    v.ev = ev; v.ed = ed; v.cd = cd; v.ec = ec; v.er = er; v.nm = nm;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic iv, input logic ib, input logic ordy, input logic clr);
    bif.in_val  = iv;
    bif.in_bit  = ib;
    bif.out_rdy = ordy;
    clear       = clr;
  endtask

  task automatic check_state(input string nm, input logic ev, input logic [7:0] ed,
                             input logic cd, input logic [2:0] ec, input logic er);
    chk({nm, "_out_val"}, 32'(bif.out_val), 32'(ev));
    if (cd) chk({nm, "_out_data"}, 32'(bif.out_data), 32'(ed));
    chk({nm, "_bit_count"}, 32'(bif.bit_count), 32'(ec));
    chk({nm, "_in_rdy"}, 32'(bif.in_rdy), 32'(er));
  endtask

  task automatic send(input logic b, input logic ordy);
    drive(1'b1, b, ordy, 1'b0);
    tick();
  endtask

  initial begin
    logic [7:0] w;
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held for two cycles, then released.
    tick();
    tick();
    check_state("rst_held", 1'b0, 8'h00, 1'b1, 3'd0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    tick();
    check_state("rst_rel", 1'b0, 8'h00, 1'b1, 3'd0, 1'b1);

    // Table: basic B2 word, then gapped 81 word, out_rdy held high.
    w = 8'hB2;
    for (int i = 0; i < 8; i++)
      add(1'b1, w[7-i], 1'b1, 1'b0, (i == 7), 8'hB2, (i == 7),
          3'((i + 1) % 8), 1'b1, "b2");
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, "b2_deq");
    w = 8'h81;
    for (int i = 0; i < 8; i++) begin
      add(1'b1, w[7-i], 1'b1, 1'b0, (i == 7), 8'h81, (i == 7),
          3'((i + 1) % 8), 1'b1, "gap_bit");
      if (i < 7)
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'(i + 1), 1'b1, "gap_idle");
    end
    add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, "gap_deq");

    foreach (vecs[k]) begin
      drive(vecs[k].iv, vecs[k].ib, vecs[k].ordy, vecs[k].clr);
      tick();
      check_state(vecs[k].nm, vecs[k].ev, vecs[k].ed, vecs[k].cd, vecs[k].ec, vecs[k].er);
    end

    // Backpressure: A5 waits while 7 bits of 3C accumulate.
    w = 8'hA5;
    for (int i = 0; i < 8; i++) send(w[7-i], 1'b0);
    check_state("bp_a5", 1'b1, 8'hA5, 1'b1, 3'd0, 1'b1);
    w = 8'h3C;
    for (int i = 0; i < 7; i++) send(w[7-i], 1'b0);
    check_state("bp_7bits", 1'b1, 8'hA5, 1'b1, 3'd7, 1'b0);
    drive(1'b1, w[0], 1'b0, 1'b0);
    #1;
    chk("bp_stall_in_rdy", 32'(bif.in_rdy), 32'd0);
    tick();
    check_state("bp_stall", 1'b1, 8'hA5, 1'b1, 3'd7, 1'b0);
    drive(1'b1, w[0], 1'b1, 1'b0);
    tick();
    check_state("bp_deq_a5", 1'b0, 8'h00, 1'b0, 3'd7, 1'b1);
    send(w[0], 1'b0);
    check_state("bp_3c", 1'b1, 8'h3C, 1'b1, 3'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_state("bp_deq_3c", 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);

    // Clear drops the partial word and the bit presented with it.
    for (int i = 0; i < 3; i++) send(1'b1, 1'b1);
    check_state("clr_pre", 1'b0, 8'h00, 1'b0, 3'd3, 1'b1);
    drive(1'b1, 1'b0, 1'b1, 1'b1);
    tick();
    check_state("clr", 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);
    for (int i = 0; i < 8; i++) send(1'b1, 1'b1);
    check_state("clr_ff", 1'b1, 8'hFF, 1'b1, 3'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_state("clr_ff_deq", 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);

    // Clear with a word pending leaves the output register alone.
    w = 8'h5A;
    for (int i = 0; i < 8; i++) send(w[7-i], 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    check_state("pend_pre", 1'b1, 8'h5A, 1'b1, 3'd2, 1'b1);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check_state("pend_clr", 1'b1, 8'h5A, 1'b1, 3'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    check_state("pend_hold", 1'b1, 8'h5A, 1'b1, 3'd0, 1'b1);
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    check_state("pend_deq", 1'b0, 8'h00, 1'b0, 3'd0, 1'b1);

    // Asynchronous reset mid-word with a word pending.
    w = 8'hC3;
    for (int i = 0; i < 8; i++) send(w[7-i], 1'b0);
    for (int i = 0; i < 5; i++) send(1'b1, 1'b0);
    check_state("arst_pre", 1'b1, 8'hC3, 1'b1, 3'd5, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_state("arst_now", 1'b0, 8'h00, 1'b1, 3'd0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    send(1'b1, 1'b0);
    check_state("arst_first", 1'b0, 8'h00, 1'b1, 3'd1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seq_bit_deserializer.md
# seq_bit_deserializer

Downstream consumer of the registered single-bit stream produced by the boolean-truth DFF stage. It accepts one bit per accepted cycle over a valid/ready handshake and packs NBITS bits MSB-first into a word. Completed words go to a one-entry output register with its own valid/ready handshake, so the next word can accumulate while the previous one waits to be consumed.

## Interface
- NBITS, default 8: word width in bits. Legal range is 2 to 32.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset. reset=0 clears all state immediately.
- clear  input  1  synchronous; discards the partial word in the shift register.
- in_val  input  1  in_bit is valid this cycle.
- in_bit  input  1  serial data bit, normally the upstream DFF q.
- in_rdy  output  1  block can accept a bit this cycle.
- out_val  output  1  out_data holds a completed word.
- out_data  output  NBITS  completed word; the first bit received is the MSB.
- out_rdy  input  1  downstream accepts the word this cycle.
- bit_count  output  $clog2(NBITS)  number of bits currently held in the partial word.

## Operation
- State:
  - shift register sreg[NBITS-1:0];
  - counter cnt, range 0..NBITS-1;
  - output register odata[NBITS-1:0] and flag ovalid.
- Input fire: in_val && in_rdy && !clear.
- Output fire: out_val && out_rdy.
- in_rdy = !(ovalid && cnt == NBITS-1).
  - in_rdy depends only on registered state. There is no combinational path from out_rdy to in_rdy.
  - While in_rdy=0, in_bit is ignored.
- Input fire with cnt < NBITS-1:
  - sreg <= {sreg[NBITS-2:0], in_bit};
  - cnt <= cnt+1.
- Input fire with cnt == NBITS-1 (completing bit):
  - odata <= {sreg[NBITS-2:0], in_bit};
  - ovalid <= 1;
  - cnt <= 0;
  - sreg <= 0.
- A completing fire can only occur when ovalid=0, or when ovalid=1 is being dequeued the same cycle. In the dequeue case the new word wins and ovalid stays 1.
  - By the in_rdy rule above, the dequeue case cannot arise with cnt == NBITS-1. It is listed for completeness and must still be handled correctly.
- Output fire without a completing input fire: ovalid <= 0. odata holds its old value; it is don't-care once out_val=0.
- out_val = ovalid; out_data = odata; bit_count = cnt.
- clear=1: cnt <= 0 and sreg <= 0.
  - Any in_val that cycle is dropped.
  - ovalid and odata are unaffected; an output fire in the same cycle still dequeues.
- Gaps in in_val leave all state unchanged.

## Timing
- Reset values (asynchronous, while reset=0): cnt=0, sreg=0, ovalid=0, odata=0.
  - Resulting outputs: out_val=0, out_data=0, bit_count=0, in_rdy=1.
- Reset asserted mid-word or with a word pending: everything is lost immediately, with no clock edge required.
- After reset deasserts, the first input fire can occur at the next rising edge.
- Latency: the completing bit accepted at edge k gives out_val=1 with the full word from just after edge k.
- Throughput: one word every NBITS cycles when out_rdy is held high.
- Backpressure with out_rdy=0:
  - up to NBITS-1 further bits are accepted;
  - then in_rdy=0 until the cycle after the output fire;
  - this costs one bubble cycle after each stall.
- bit_count updates on the same edge as the accepted bit.

## Test plan
- Reset: hold reset=0 for 2 cycles, then release. Required: out_val=0, out_data=0, bit_count=0, in_rdy=1. Also pull reset=0 mid-cycle after 5 bits; bit_count must drop to 0 before the next edge.
- Basic word (NBITS=8, out_rdy=1): feed 1,0,1,1,0,0,1,0 on consecutive cycles. Required: out_val=1 with out_data=8'hB2 in the cycle after the 8th bit, then out_val=0 the following cycle.
- Backpressure:
  - With out_rdy=0, feed A5 (1,0,1,0,0,1,0,1), then 7 bits of 3C. Required: in_rdy=0 while the 8th bit of 3C is presented, and out_data stays A5.
  - Raise out_rdy for one cycle, then present the 8th bit of 3C. Required: A5 dequeued; in_rdy=1 the next cycle; the 8th bit is accepted; out_data=8'h3C.
- Clear: feed 1,1,1, then clear=1 with in_val=1 and in_bit=0. Required: bit_count=0. Then feed eight 1s; required: out_data=8'hFF.
- Gapped input: feed the 8'h81 bits with in_val=0 cycles between them. Required: bit_count steps only on valid cycles; out_data=8'h81 after the 8th valid bit.
- Clear with pending word: with out_val=1 (8'h5A) and out_rdy=0, assert clear. Required: out_val stays 1 and out_data stays 5A until dequeued.
